// File: rtl/timer_tb_rd_ctl.sv
// timer_tb_rd_ctl: mfspr read path for the 64-bit time base with a coherent upper-half snapshot.
// Ports:
//   CB, coreResetNEG            - core clock, synchronous active-low reset
//   PCL_mfSPR, PCL_sprHold      - mfspr request valid / pipe hold
//   tblRdDcd, tbuRdDcd          - SPR number decodes to TBL / TBU
//   tbl, tbh                    - live time base halves
//   cIn, freezeTimersNEG        - carry from tbl into tbh this cycle / timers running
//   tbWrite                     - committed mtspr to either time base half
//   tbRdData, tbRdValid         - registered read result and its one-cycle valid pulse
//   tbSnapValid                 - an upper-half snapshot is held for the next TBU read
module timer_tb_rd_ctl (
    input  logic        CB,
    input  logic        coreResetNEG,
    input  logic        PCL_mfSPR,
    input  logic        PCL_sprHold,
    input  logic        tblRdDcd,
    input  logic        tbuRdDcd,
    input  logic [31:0] tbl,
    input  logic [31:0] tbh,
    input  logic        cIn,
    input  logic        freezeTimersNEG,
    input  logic        tbWrite,
    output logic [31:0] tbRdData,
    output logic        tbRdValid,
    output logic        tbSnapValid
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} stateType;
    stateType state, nextState;
    logic [31:0] snapshot;
    logic req, capture;
    always_comb begin
        req       = PCL_mfSPR & (tblRdDcd | tbuRdDcd);
        capture   = req & ~PCL_sprHold;
        nextState = req ? (PCL_sprHold ? HOLD : DONE) : IDLE;
        tbRdValid = state == DONE;
    end
    always_ff @(posedge CB) begin
        if (!coreResetNEG) begin
            state       <= IDLE;
            tbRdData    <= '0;
            tbSnapValid <= 1'b0;
            snapshot    <= '0;
        end else begin
            state <= nextState;
            // both decodes high counts as a TBL read
            if (capture)
                tbRdData <= tblRdDcd ? tbl : (tbSnapValid ? snapshot : tbh);
            // tbh only advances at the next edge, so fold a pending carry into the snapshot
            if (capture & tblRdDcd)
                snapshot <= tbh + 32'(cIn & freezeTimersNEG);
            tbSnapValid <= tbWrite ? 1'b0 : (capture ? tblRdDcd : tbSnapValid);
        end
    end
endmodule

// File: tb/tb_timer_tb_rd_ctl.sv
// tb_timer_tb_rd_ctl: randomized and directed checks of timer_tb_rd_ctl against a behavioural model.
module tb_timer_tb_rd_ctl;
    logic        CB = 1'b0;
    logic        coreResetNEG = 1'b0;
    logic        PCL_mfSPR = 1'b0, PCL_sprHold = 1'b0, tblRdDcd = 1'b0, tbuRdDcd = 1'b0;
    logic [31:0] tbl = '0, tbh = '0;
    logic        cIn = 1'b0, freezeTimersNEG = 1'b1, tbWrite = 1'b0;
    logic [31:0] tbRdData;
    logic        tbRdValid, tbSnapValid;

    int checks = 0, errors = 0;
    logic        armed = 1'b0;
    logic [31:0] mData = '0, mSnap = '0;
    logic        mValid = 1'b0, mSnapV = 1'b0;

    timer_tb_rd_ctl dut (
        .CB(CB), .coreResetNEG(coreResetNEG), .PCL_mfSPR(PCL_mfSPR), .PCL_sprHold(PCL_sprHold),
        .tblRdDcd(tblRdDcd), .tbuRdDcd(tbuRdDcd), .tbl(tbl), .tbh(tbh), .cIn(cIn),
        .freezeTimersNEG(freezeTimersNEG), .tbWrite(tbWrite), .tbRdData(tbRdData),
        .tbRdValid(tbRdValid), .tbSnapValid(tbSnapValid)
    );

    always #5 CB = ~CB;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: check outputs of the previous edge, apply new inputs, predict the next edge
    task automatic cycle(input logic mf, input logic hold, input logic l, input logic u,
                         input logic [31:0] vl, input logic [31:0] vh, input logic c,
                         input logic fz, input logic w, input logic rn);
        logic cap;
        @(negedge CB);
        if (armed) begin
            checkVal("tbRdData", tbRdData, mData);
            checkVal("tbRdValid", 32'(tbRdValid), 32'(mValid));
            checkVal("tbSnapValid", 32'(tbSnapValid), 32'(mSnapV));
        end
        armed = 1'b1;
        PCL_mfSPR = mf; PCL_sprHold = hold; tblRdDcd = l; tbuRdDcd = u;
        tbl = vl; tbh = vh; cIn = c; freezeTimersNEG = fz; tbWrite = w; coreResetNEG = rn;
        if (!rn) begin
            mData = '0; mSnap = '0; mValid = 1'b0; mSnapV = 1'b0;
        end else begin
            cap = mf & (l | u) & ~hold;
            mValid = cap;
            if (cap && l) begin
                mData = vl;
                mSnap = vh + ((c && fz) ? 32'd1 : 32'd0);
            end else if (cap) begin
                mData = mSnapV ? mSnap : vh;
            end
            mSnapV = w ? 1'b0 : (cap ? l : mSnapV);
        end
    endtask

    task automatic idle(input logic [31:0] vh);
        cycle(0, 0, 0, 0, 32'h0, vh, 0, 1, 0, 1);
    endtask

    initial begin
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 32'hdead, 32'h5, 0, 1, 0, 0);
        idle(0);
        // basic TBL read
        cycle(1, 0, 1, 0, 32'h12345678, 32'h1, 0, 1, 0, 1);
        idle(1);
        // carry folded into snapshot, then TBU read sees snapshot not live tbh
        cycle(1, 0, 1, 0, 32'hffffffff, 32'h7, 1, 1, 0, 1);
        cycle(1, 0, 0, 1, 32'h0, 32'h8, 0, 1, 0, 1);
        idle(8);
        // frozen vs running wrap at tbh = all ones
        cycle(1, 0, 1, 0, 32'hffffffff, 32'hffffffff, 1, 0, 0, 1);
        cycle(1, 0, 0, 1, 32'h0, 32'h0, 0, 1, 0, 1);
        cycle(1, 0, 1, 0, 32'hffffffff, 32'hffffffff, 1, 1, 0, 1);
        cycle(1, 0, 0, 1, 32'h0, 32'h1234, 0, 1, 0, 1);
        idle(0);
        // held 3 cycles, capture on release
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 32'h100 + i, 32'h2, 0, 1, 0, 1);
        cycle(1, 0, 1, 0, 32'hcafe0001, 32'h2, 0, 1, 0, 1);
        idle(2);
        // hold cancelled
        cycle(1, 1, 0, 1, 0, 32'h3, 0, 1, 0, 1);
        cycle(0, 1, 0, 1, 0, 32'h3, 0, 1, 0, 1);
        idle(3);
        // tbWrite overrides snapshot set; TBU gets live tbh
        cycle(1, 0, 1, 1, 32'h55, 32'h9, 1, 1, 1, 1);
        cycle(1, 0, 0, 1, 0, 32'habc, 0, 1, 0, 1);
        idle(0);
        // reset in HOLD, then normal read
        cycle(1, 1, 1, 0, 32'h77, 32'h4, 0, 1, 0, 1);
        cycle(1, 1, 1, 0, 32'h77, 32'h4, 0, 1, 0, 0);
        idle(4);
        cycle(1, 0, 1, 0, 32'h88, 32'h4, 0, 1, 0, 1);
        idle(4);
        for (int i = 0; i < 3000; i++)
            cycle($urandom % 4 != 0, $urandom % 3 == 0, 1'($urandom), 1'($urandom),
                  $urandom, ($urandom % 4 == 0) ? 32'hffffffff : $urandom,
                  1'($urandom), $urandom % 4 != 0, $urandom % 8 == 0, $urandom % 60 != 0);
        idle(0);
        idle(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_tb_rd_ctl.md
TIMER_TB_RD_CTL -- requirements
Module: timer_tb_rd_ctl

Interface
REQ-001 SHALL have port CB, input, 1, core clock; all state changes on rising edge.
REQ-002 SHALL have port coreResetNEG, input, 1, reset; reset is synchronous and active-low.
REQ-003 SHALL have port PCL_mfSPR, input, 1, mfspr request valid this cycle.
REQ-004 SHALL have port PCL_sprHold, input, 1, pipe hold; request not yet executable.
REQ-005 SHALL have port tblRdDcd, input, 1, SPR number decodes to time base lower.
REQ-006 SHALL have port tbuRdDcd, input, 1, SPR number decodes to time base upper.
REQ-007 SHALL have port tbl, input, 32, current time base lower value.
REQ-008 SHALL have port tbh, input, 32, current time base upper value.
REQ-009 SHALL have port cIn, input, 1, carry from tbl into tbh this cycle; tbh updates at next edge.
REQ-010 SHALL have port freezeTimersNEG, input, 1, low = timers frozen, carry ignored.
REQ-011 SHALL have port tbWrite, input, 1, committed mtspr to either time base half this cycle.
REQ-012 SHALL have port tbRdData, output, 32, registered read result.
REQ-013 SHALL have port tbRdValid, output, 1, tbRdData valid, one-cycle pulse.
REQ-014 SHALL have port tbSnapValid, output, 1, upper-half snapshot held.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, DONE.
REQ-016 A request SHALL exist when PCL_mfSPR & (tblRdDcd | tbuRdDcd); other cycles are not requests.
REQ-017 Request with PCL_sprHold high SHALL move state to HOLD with no capture and no output change.
REQ-018 In HOLD, SHALL remain while PCL_sprHold high; SHALL capture on first cycle with request present and PCL_sprHold low.
REQ-019 HOLD with PCL_mfSPR dropped SHALL return to IDLE with no capture (request cancelled).
REQ-020 Capture cycle SHALL transition to DONE; tbRdValid SHALL be 1 in exactly the following cycle.
REQ-021 DONE SHALL go to IDLE when no request, HOLD on held request, stay DONE on an unheld request (back-to-back reads, one result per cycle).
REQ-022 Latency: capture edge to tbRdValid = 1 cycle; tbRdData SHALL hold its value until the next capture.
REQ-023 tblRdDcd and tbuRdDcd both high SHALL be treated as a TBL read.
REQ-024 TBL capture: tbRdData <= tbl; snapshot <= tbh + 1 (mod 2^32) if cIn & freezeTimersNEG, else tbh; tbSnapValid <= 1.
REQ-025 TBU capture with tbSnapValid=1: tbRdData <= snapshot; tbSnapValid <= 0.
REQ-026 TBU capture with tbSnapValid=0: tbRdData <= tbh (live value, no carry adjust).
REQ-027 tbWrite high SHALL clear tbSnapValid at the next edge, overriding a same-cycle TBL capture set.
REQ-028 tbh = 0xFFFFFFFF with qualified carry SHALL wrap snapshot to 0x00000000.
REQ-029 A second TBL capture before any TBU read SHALL overwrite the snapshot.

Reset
REQ-030 coreResetNEG low at an edge SHALL force state IDLE, tbRdData 0, tbRdValid 0, tbSnapValid 0, snapshot 0.
REQ-031 Reset SHALL override any capture or HOLD in progress; no tbRdValid pulse after reset for a pre-reset request.

Verification
REQ-032 TBL read, tbl=0x12345678, tbh=0x1, cIn=0 -> next cycle tbRdValid=1, tbRdData=0x12345678, tbSnapValid=1.
REQ-033 TBL read with tbl=0xFFFFFFFF, tbh=0x7, cIn=1, freezeTimersNEG=1, then TBU read with live tbh=0x8 -> TBU tbRdData=0x8 from snapshot, tbSnapValid=0 after.
REQ-034 Same as REQ-033 with freezeTimersNEG=0 and tbh=0xFFFFFFFF held -> snapshot 0xFFFFFFFF; with freeze=1 -> 0x00000000.
REQ-035 TBL read held 3 cycles by PCL_sprHold -> no tbRdValid during hold; capture on release; tbRdValid one cycle later with tbl of release cycle.
REQ-036 TBL capture coinciding with tbWrite=1, then TBU read -> tbSnapValid=0, tbRdData=live tbh.
REQ-037 Reset asserted in HOLD -> all outputs 0, IDLE; subsequent read completes normally.
